ysyx_25040111_csru: RTL and testbench

YSYX_25040111_CSRU -- requirements
Module: ysyx_25040111_csru

---
 rtl/ysyx_25040111_csr_pkg.sv | 34 +++
 rtl/ysyx_25040111_cnt64.sv | 53 +++++
 rtl/ysyx_25040111_csru.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_25040111_csru.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_csr_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_csr_pkg
// Shared definitions for the machine-mode CSR unit: CSR addresses, the
// csr_op encoding and mstatus bit positions.
// ---------------------------------------------------------------------------
package ysyx_25040111_csr_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
   localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/ysyx_25040111_cnt64.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_cnt64
// 64-bit free-running event counter with independently writable halves.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears the count
//   inc    : add one this cycle
//   wr_lo  : replace count[31:0] with wdata
//   wr_hi  : replace count[63:32] with wdata
//   wdata  : write data for either half
//   count  : current 64-bit value
// A write to either half suppresses the increment for that cycle; the
// half not being written keeps its value.
// ---------------------------------------------------------------------------
module ysyx_25040111_cnt64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   logic [31:0] lo;
   logic [31:0] hi;
   logic        step;
   logic [32:0] lo_sum;

   always_comb begin
      step   = inc & ~wr_lo & ~wr_hi;
      lo_sum = {1'b0, lo} + 33'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo <= '0;
         hi <= '0;
      end else begin
         if (wr_lo)
            lo <= wdata;
         else if (step)
            lo <= lo_sum[31:0];
         // low-half overflow carries into the high half on the same edge
         if (wr_hi)
            hi <= wdata;
         else if (step)
            hi <= hi + {31'd0, lo_sum[32]};
      end
   end

   assign count = {hi, lo};

endmodule

// File: rtl/ysyx_25040111_csru.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_csru
// Machine-mode CSR unit: CSR read/modify/write, trap entry, mret and the
// mcycle/minstret counters.
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   csr_op       : 00 none, 01 RW, 10 RS, 11 RC
//   csr_addr     : CSR address
//   csr_src      : operand for write/set/clear
//   csr_rdata    : pre-edge value of the addressed CSR (0 if illegal)
//   csr_illegal  : unknown address, or effective write to read-only CSR
//   trap_valid   : trap entry (trap_cause, trap_pc)
//   mret         : trap return
//   retire       : one instruction retired this cycle
//   redirect_pc  : mtvec on trap, mepc on mret, else 0
//   mie          : mstatus.MIE
// ---------------------------------------------------------------------------
module ysyx_25040111_csru
   import ysyx_25040111_csr_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] MVENDORID    = 32'h79737978,
   parameter logic [XLEN-1:0] MARCHID      = 32'd25040111,
   parameter int              HAS_COUNTERS = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_src,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   input  logic            retire,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mie
);

   csr_op_e op;

   logic            mie_q;
   logic            mpie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [63:0]     mcycle;
   logic [63:0]     minstret;

   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] old_val;
   logic [XLEN-1:0] new_val;
   logic            known;
   logic            read_only;
   logic            wr_req;
   logic            we;

   assign op = csr_op_e'(csr_op);

   // Only MIE/MPIE are stored; MPP reads as machine mode.
   always_comb begin
      mstatus_val = '0;
      mstatus_val[MSTATUS_MIE]                   = mie_q;
      mstatus_val[MSTATUS_MPIE]                  = mpie_q;
      mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   always_comb begin
      known     = 1'b1;
      read_only = 1'b0;
      old_val   = '0;
      case (csr_addr)
         ADDR_MSTATUS:   old_val = mstatus_val;
         ADDR_MTVEC:     old_val = mtvec_q;
         ADDR_MSCRATCH:  old_val = mscratch_q;
         ADDR_MEPC:      old_val = mepc_q;
         ADDR_MCAUSE:    old_val = mcause_q;
         ADDR_MCYCLE: begin
            known   = (HAS_COUNTERS != 0);
            old_val = XLEN'(mcycle[31:0]);
         end
         ADDR_MCYCLEH: begin
            known   = (HAS_COUNTERS != 0);
            old_val = XLEN'(mcycle[63:32]);
         end
         ADDR_MINSTRET: begin
            known   = (HAS_COUNTERS != 0);
            old_val = XLEN'(minstret[31:0]);
         end
         ADDR_MINSTRETH: begin
            known   = (HAS_COUNTERS != 0);
            old_val = XLEN'(minstret[63:32]);
         end
         ADDR_MVENDORID: begin
            read_only = 1'b1;
            old_val   = MVENDORID;
         end
         ADDR_MARCHID: begin
            read_only = 1'b1;
            old_val   = MARCHID;
         end
         ADDR_MIMPID,
         ADDR_MHARTID:   read_only = 1'b1;
         default:        known = 1'b0;
      endcase
   end

   // RS/RC with a zero operand are pure reads and never write.
   always_comb begin
      wr_req = (op == CSR_OP_RW) ||
               (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (csr_src != '0));
      case (op)
         CSR_OP_RW: new_val = csr_src;
         CSR_OP_RS: new_val = old_val | csr_src;
         CSR_OP_RC: new_val = old_val & ~csr_src;
         default:   new_val = old_val;
      endcase
      csr_illegal = ~known | (read_only & wr_req);
      csr_rdata   = csr_illegal ? '0 : old_val;
      we          = wr_req & ~csr_illegal;
   end

   always_comb begin
      if (trap_valid)
         redirect_pc = mtvec_q;
      else if (mret)
         redirect_pc = mepc_q;
      else
         redirect_pc = '0;
   end

   assign mie = mie_q;

   // Trap entry overrides mret, which overrides a software write to mstatus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie_q  <= 1'b0;
         mpie_q <= 1'b0;
      end else if (trap_valid) begin
         mpie_q <= mie_q;
         mie_q  <= 1'b0;
      end else if (mret) begin
         mie_q  <= mpie_q;
         mpie_q <= 1'b1;
      end else if (we && csr_addr == ADDR_MSTATUS) begin
         mie_q  <= new_val[MSTATUS_MIE];
         mpie_q <= new_val[MSTATUS_MPIE];
      end
   end

   // mepc/mcause are owned by trap entry when it coincides with a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (trap_valid) begin
         mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
         mcause_q <= trap_cause;
      end else if (we) begin
         if (csr_addr == ADDR_MEPC)
            mepc_q <= {new_val[XLEN-1:2], 2'b00};
         if (csr_addr == ADDR_MCAUSE)
            mcause_q <= new_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtvec_q    <= '0;
         mscratch_q <= '0;
      end else if (we) begin
         if (csr_addr == ADDR_MTVEC)
            mtvec_q <= {new_val[XLEN-1:2], 2'b00};
         if (csr_addr == ADDR_MSCRATCH)
            mscratch_q <= new_val;
      end
   end

   generate
      if (HAS_COUNTERS != 0) begin : g_counters
         ysyx_25040111_cnt64 u_mcycle (
            .clk   (clk),
            .reset (reset),
            .inc   (1'b1),
            .wr_lo (we && csr_addr == ADDR_MCYCLE),
            .wr_hi (we && csr_addr == ADDR_MCYCLEH),
            .wdata (new_val[31:0]),
            .count (mcycle)
         );
         ysyx_25040111_cnt64 u_minstret (
            .clk   (clk),
            .reset (reset),
            .inc   (retire),
            .wr_lo (we && csr_addr == ADDR_MINSTRET),
            .wr_hi (we && csr_addr == ADDR_MINSTRETH),
            .wdata (new_val[31:0]),
            .count (minstret)
         );
      end else begin : g_no_counters
         assign mcycle   = '0;
         assign minstret = '0;
      end
   endgenerate

endmodule

// File: tb/tb_ysyx_25040111_csru.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040111_csru
// Directed self-checking bench for the CSR unit. Inputs change just after
// the falling edge; outputs are sampled 1 time unit later, well before the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_25040111_csru;

   logic        clk;
   logic        reset;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_src;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic        mret;
   logic        retire;
   logic [31:0] redirect_pc;
   logic        mie;

   int checks = 0;
   int errors = 0;

   ysyx_25040111_csru dut (
      .clk         (clk),
      .reset       (reset),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_src     (csr_src),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .trap_valid  (trap_valid),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .mret        (mret),
      .retire      (retire),
      .redirect_pc (redirect_pc),
      .mie         (mie)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s);
      csr_op   = op;
      csr_addr = a;
      csr_src  = s;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      drive(2'b00, a, 32'h0);
      #1;
      chk(tag, csr_rdata, exp);
      chk({tag, "_ill"}, 32'(csr_illegal), 32'h0);
   endtask

   initial begin
      reset = 1'b0;
      drive(2'b00, 12'h000, 32'h0);
      trap_valid = 1'b0;
      trap_cause = '0;
      trap_pc    = '0;
      mret       = 1'b0;
      retire     = 1'b0;

      // reset state is visible without any clock edge
      #2 reset = 1'b1;
      #1;
      rd("rst_mstatus", 12'h300, 32'h00001800);
      chk("rst_mie", 32'(mie), 32'h0);
      chk("rst_redirect", redirect_pc, 32'h0);
      rd("rst_mepc", 12'h341, 32'h0);
      rd("rst_mcycle", 12'hB00, 32'h0);

      // writes and retire are ignored while reset is held
      drive(2'b01, 12'h340, 32'hDEADBEEF);
      retire = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      retire = 1'b0;
      drive(2'b00, 12'h000, 32'h0);
      rd("rst_mscratch", 12'h340, 32'h0);
      rd("rst_mcycle0", 12'hB00, 32'h0);
      rd("rst_minstret", 12'hB02, 32'h0);
      tick();
      rd("mcycle_first", 12'hB00, 32'd1);

      // basic reads
      rd("mstatus_rd", 12'h300, 32'h00001800);
      rd("marchid", 12'hF12, 32'd25040111);
      rd("mvendorid", 12'hF11, 32'h79737978);
      tick();

      // mtvec write with low bits forced to zero
      drive(2'b01, 12'h305, 32'h80000103);
      #1;
      chk("mtvec_old", csr_rdata, 32'h0);
      chk("mtvec_wr_ill", 32'(csr_illegal), 32'h0);
      tick();
      rd("mtvec", 12'h305, 32'h80000100);

      // trap entry
      trap_valid = 1'b1;
      trap_pc    = 32'h80000046;
      trap_cause = 32'd11;
      #1;
      chk("redir_trap", redirect_pc, 32'h80000100);
      tick();
      trap_valid = 1'b0;
      rd("trap_mepc", 12'h341, 32'h80000044);
      rd("trap_mcause", 12'h342, 32'd11);
      chk("trap_mie", 32'(mie), 32'h0);
      rd("trap_mstatus", 12'h300, 32'h00001800);
      chk("redir_idle", redirect_pc, 32'h0);

      // enable MIE, trap, then mret
      drive(2'b10, 12'h300, 32'h8);
      #1;
      chk("rs_mstatus_old", csr_rdata, 32'h00001800);
      tick();
      rd("mie_set_mstatus", 12'h300, 32'h00001808);
      chk("mie_set", 32'(mie), 32'h1);
      trap_valid = 1'b1;
      trap_pc    = 32'h80000200;
      trap_cause = 32'd3;
      tick();
      trap_valid = 1'b0;
      rd("trap2_mstatus", 12'h300, 32'h00001880);
      chk("trap2_mie", 32'(mie), 32'h0);
      rd("trap2_mepc", 12'h341, 32'h80000200);
      mret = 1'b1;
      #1;
      chk("redir_mret", redirect_pc, 32'h80000200);
      tick();
      mret = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h00001888);
      chk("mret_mie", 32'(mie), 32'h1);

      // read-only and unknown addresses
      drive(2'b01, 12'hF11, 32'h12345678);
      #1;
      chk("ro_rw_ill", 32'(csr_illegal), 32'h1);
      chk("ro_rw_rdata", csr_rdata, 32'h0);
      tick();
      rd("ro_unchanged", 12'hF11, 32'h79737978);
      drive(2'b10, 12'hF11, 32'h0);
      #1;
      chk("ro_rs0_ill", 32'(csr_illegal), 32'h0);
      chk("ro_rs0_rdata", csr_rdata, 32'h79737978);
      drive(2'b11, 12'hF12, 32'h0);
      #1;
      chk("ro_rc0_ill", 32'(csr_illegal), 32'h0);
      drive(2'b10, 12'h7C0, 32'h0);
      #1;
      chk("unk_ill", 32'(csr_illegal), 32'h1);
      chk("unk_rdata", csr_rdata, 32'h0);
      tick();

      // set/clear on mscratch
      drive(2'b01, 12'h340, 32'hFFFF00FF);
      tick();
      drive(2'b11, 12'h340, 32'h0F0F0F0F);
      #1;
      chk("rc_old", csr_rdata, 32'hFFFF00FF);
      tick();
      drive(2'b10, 12'h340, 32'h00000F00);
      #1;
      chk("rs_old", csr_rdata, 32'hF0F000F0);
      tick();
      rd("mscratch_final", 12'h340, 32'hF0F00FF0);

      // mstatus writable mask
      drive(2'b01, 12'h300, 32'h0);
      tick();
      rd("mstatus_zero", 12'h300, 32'h00001800);
      chk("mstatus_zero_mie", 32'(mie), 32'h0);
      drive(2'b01, 12'h300, 32'hFFFFFFFF);
      tick();
      rd("mstatus_ones", 12'h300, 32'h00001888);
      chk("mstatus_ones_mie", 32'(mie), 32'h1);

      // mepc software write alignment
      drive(2'b01, 12'h341, 32'h80000123);
      tick();
      rd("mepc_wr", 12'h341, 32'h80000120);

      // mcycle carry into mcycleh
      drive(2'b01, 12'hB00, 32'hFFFFFFFF);
      tick();
      drive(2'b01, 12'hB80, 32'h0);
      #1;
      chk("mcycleh_old", csr_rdata, 32'h0);
      tick();
      rd("mcycle_lo_held", 12'hB00, 32'hFFFFFFFF);
      rd("mcycleh_zero", 12'hB80, 32'h0);
      tick();
      rd("mcycleh_carry", 12'hB80, 32'h1);
      rd("mcycle_wrap", 12'hB00, 32'h0);

      // minstret counts retire cycles, with carry
      drive(2'b01, 12'hB02, 32'hFFFFFFFE);
      tick();
      drive(2'b00, 12'h000, 32'h0);
      retire = 1'b1;
      tick();
      tick();
      tick();
      retire = 1'b0;
      rd("minstret_lo", 12'hB02, 32'h1);
      rd("minstret_hi", 12'hB82, 32'h1);

      // trap, mret and mepc write together: trap wins
      trap_valid = 1'b1;
      trap_pc    = 32'h80000300;
      trap_cause = 32'd7;
      mret       = 1'b1;
      drive(2'b01, 12'h341, 32'h11111110);
      #1;
      chk("coinc_redirect", redirect_pc, 32'h80000100);
      chk("coinc_rdata", csr_rdata, 32'h80000120);
      tick();
      trap_valid = 1'b0;
      mret       = 1'b0;
      rd("coinc_mepc", 12'h341, 32'h80000300);
      rd("coinc_mcause", 12'h342, 32'd7);
      rd("coinc_mstatus", 12'h300, 32'h00001880);
      chk("coinc_mie", 32'(mie), 32'h0);

      // asynchronous reset in the middle of a trap
      trap_valid = 1'b1;
      trap_pc    = 32'h80000400;
      trap_cause = 32'd2;
      #1;
      chk("mid_redirect", redirect_pc, 32'h80000100);
      #2 reset = 1'b1;
      #1;
      chk("arst_mie", 32'(mie), 32'h0);
      rd("arst_mstatus", 12'h300, 32'h00001800);
      rd("arst_mtvec", 12'h305, 32'h0);
      chk("arst_redirect", redirect_pc, 32'h0);
      rd("arst_mepc", 12'h341, 32'h0);
      rd("arst_mcause", 12'h342, 32'h0);
      rd("arst_mcycle", 12'hB00, 32'h0);
      trap_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
